// File: rtl/adder_arb_pkg.sv
// Shared definitions for the adder arbiter: requester count default,
// response-id width derivation and the result-holding state type.
// Operand width comes from the BITWIDTH macro (defaults to 8 if unset).
`ifndef BITWIDTH
`define BITWIDTH 8
`endif

package adder_arb_pkg;

  localparam int NUM_REQ_DEFAULT = 4;

  // Width of a requester index. A single-requester build still needs a
  // one-bit id, so the degenerate case is clamped rather than left at zero.
  function automatic int idWidth(input int numReq);
    return (numReq > 1) ? $clog2(numReq) : 1;
  endfunction

  typedef enum logic {
    IDLE = 1'b0,  // no result held
    FULL = 1'b1   // result register holds a result
  } state_t;

endpackage

// File: rtl/adder_arbiter_adder.sv
// Purpose: combinational W-bit adder with the carry kept as the top result bit.
// Latency: 0 cycles (pure combinational); the caller registers the sum.
// Backpressure: none, no handshake at this level.
// Ports: iA, iB operands [W-1:0]; oSum = iA + iB, [W:0].
module adder #(
  parameter int W = `BITWIDTH
) (
  input  logic [W-1:0] iA,
  input  logic [W-1:0] iB,
  output logic [W:0]   oSum
);

  assign oSum = {1'b0, iA} + {1'b0, iB};

endmodule

// File: rtl/adder_arbiter.sv
// Purpose: shares one adder among NUM_REQ requesters; a registered sum and
//          the owning requester id are returned on a valid/ready response.
// Latency: 1 cycle from accept to oRspValid; 1 result per cycle sustained.
// Backpressure: while a result is held and iRspReady=0 no request is granted
//          and the response holds stable.
// Ports: iClk, iRstN (async active-low), iEn (global hold), iClr (sync clear);
//        iReqValid/iReqData0/iReqData1/oReqReady per-requester request side;
//        oRspValid/iRspReady/oRspId/oRspData response side.
// Config: define ADDER_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority;
//         default build uses round-robin with a rotating priority pointer.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT,
  parameter int ID_W    = idWidth(NUM_REQ)
) (
  input  logic                                iClk,
  input  logic                                iRstN,
  input  logic                                iEn,
  input  logic                                iClr,
  input  logic [NUM_REQ-1:0]                  iReqValid,
  input  logic [NUM_REQ-1:0][`BITWIDTH-1:0]   iReqData0,
  input  logic [NUM_REQ-1:0][`BITWIDTH-1:0]   iReqData1,
  output logic [NUM_REQ-1:0]                  oReqReady,
  output logic                                oRspValid,
  input  logic                                iRspReady,
  output logic [ID_W-1:0]                     oRspId,
  output logic [`BITWIDTH:0]                  oRspData
);

  state_t            state;
  logic              canAccept;
  logic              anyValid;
  logic              accept;
  logic [ID_W-1:0]   winId;
  logic [`BITWIDTH-1:0] opA;
  logic [`BITWIDTH-1:0] opB;
  logic [`BITWIDTH:0]   sum;

  // A slot opens when nothing is held, or when the held result leaves this
  // same cycle. Reset is folded in so the grant is forced low asynchronously.
  assign canAccept = iRstN & iEn & ~iClr & ((state == IDLE) | iRspReady);
  assign accept    = canAccept & anyValid;

`ifdef ADDER_ARB_FIXED_PRIO_EN
  // Scan high to low so the lowest-index valid requester is the last writer.
  always_comb begin
    winId    = '0;
    anyValid = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (iReqValid[i]) begin
        anyValid = 1'b1;
        winId    = ID_W'(i);
      end
    end
  end
`else
  logic [ID_W-1:0] ptr;
  int              idx;

  // Search starts at the pointer and wraps; the first valid index wins.
  always_comb begin
    winId    = '0;
    anyValid = 1'b0;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!anyValid && iReqValid[idx]) begin
        anyValid = 1'b1;
        winId    = ID_W'(idx);
      end
    end
  end

  // Pointer moves only on a grant; clear returns it to requester 0.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      ptr <= '0;
    end else if (iEn) begin
      if (iClr) begin
        ptr <= '0;
      end else if (accept) begin
        ptr <= (winId == ID_W'(NUM_REQ - 1)) ? '0 : winId + 1'b1;
      end
    end
  end
`endif

  always_comb begin
    oReqReady = '0;
    if (accept) begin
      oReqReady[winId] = 1'b1;
    end
  end

  // Operands of the winner are steered into the single shared adder.
  assign opA = iReqData0[winId];
  assign opB = iReqData1[winId];

  adder #(
    .W(`BITWIDTH)
  ) uAdder (
    .iA  (opA),
    .iB  (opB),
    .oSum(sum)
  );

  // Clear wins over a same-cycle accept or handshake. An accept overwrites
  // the held result, which covers the back-to-back case where the previous
  // result is consumed in the same cycle.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state    <= IDLE;
      oRspId   <= '0;
      oRspData <= '0;
    end else if (iEn) begin
      if (iClr) begin
        state    <= IDLE;
        oRspId   <= '0;
        oRspData <= '0;
      end else if (accept) begin
        state    <= FULL;
        oRspId   <= winId;
        oRspData <= sum;
      end else if ((state == FULL) && iRspReady) begin
        state <= IDLE;
      end
    end
  end

  assign oRspValid = (state == FULL);

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: iClk  in  1  clock; iRstN  in  1  async active-low reset.
REQ-002 The block SHALL have the port iEn  in  1  global enable; when 0, all state holds.
REQ-003 The block SHALL have the port iClr  in  1  synchronous clear.
REQ-004 The block SHALL have the port iReqValid  in  NUM_REQ  per-requester request valid.
REQ-005 The block SHALL have the ports iReqData0 / iReqData1  in  NUM_REQ x `BITWIDTH  per-requester operands.
REQ-006 The block SHALL have the port oReqReady  out  NUM_REQ  one-hot grant; a request is accepted when iReqValid[i] & oReqReady[i].
REQ-007 The block SHALL have the port oRspValid  out  1  result valid.
REQ-008 The block SHALL have the port iRspReady  in  1  consumer accepts result.
REQ-009 The block SHALL have the port oRspId  out  ID_W  index of the requester that owns the result.
REQ-010 The block SHALL have the port oRspData  out  `BITWIDTH+1  registered sum, carry included.
REQ-011 The block SHALL use these parameters (name, default, meaning): NUM_REQ, 4, requester count; ID_W, $clog2(NUM_REQ), width of oRspId.

Function
REQ-012 The block SHALL share a single adder instance between NUM_REQ requesters, with at most one accept per cycle.
REQ-013 The FSM SHALL have two states. IDLE means no result is held. FULL means the result register holds a result.
REQ-014 oReqReady SHALL be nonzero only when iEn=1, iClr=0, and either the state is IDLE or (state is FULL and iRspReady=1).
REQ-015 When the condition in REQ-014 holds, oReqReady SHALL be one-hot on the winning valid requester. Otherwise oReqReady SHALL be all-zero. oReqReady may depend combinationally on iReqValid.
REQ-016 On accept from requester i, the next cycle SHALL show oRspValid=1, oRspId=i, and oRspData = iReqData0[i] + iReqData1[i], zero-extended to `BITWIDTH+1 bits with no truncation. Latency is 1 cycle.
REQ-017 A result handshake occurs when oRspValid & iRspReady. After a handshake with no same-cycle accept, the state SHALL go FULL->IDLE. After a handshake with a same-cycle accept, the state SHALL stay FULL with the new result. Throughput is 1 result per cycle.
REQ-018 While FULL and iRspReady=0, oRspValid, oRspId and oRspData SHALL hold stable.
REQ-019 Arbitration SHALL be round-robin. A priority pointer starts at 0. After a grant to i, the pointer SHALL become (i+1) mod NUM_REQ. The pointer SHALL NOT change without a grant.
REQ-020 When iEn=0, the block SHALL grant nothing, and the FSM, pointer and outputs SHALL hold.
REQ-021 When iClr=1 and iEn=1, at the next edge the block SHALL enter IDLE, drop any held result, and reset the pointer to 0. No accept SHALL occur that cycle, even with a valid request. iClr SHALL take precedence over a same-cycle accept or handshake.

Reset
REQ-022 While iRstN=0, the block SHALL asynchronously force: state IDLE, pointer 0, oRspValid=0, oRspId=0, oRspData=0, oReqReady=0.
REQ-023 Reset asserted mid-operation SHALL discard the held result with no response issued. After iRstN deasserts, the first grant SHALL follow requester-0 priority.

Configuration
REQ-024 With ADDER_ARB_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority: the lowest-index valid requester wins, and the pointer logic SHALL be compiled out.
REQ-025 Without ADDER_ARB_FIXED_PRIO_EN, arbitration SHALL be round-robin per REQ-019.

Structure
REQ-026 Package adder_arb_pkg SHALL hold the NUM_REQ default, the ID_W derivation, and the state enum type (IDLE, FULL).
REQ-027 The block SHALL instantiate the existing adder as its only sub-module, and SHALL register the adder output in the arbiter.

Verification (BITWIDTH=8, NUM_REQ=4)
REQ-028 Single request: iReqValid=0001, operands 10,20 -> oReqReady=0001 at the accept edge; next cycle oRspValid=1, oRspId=0, oRspData=30.
REQ-029 Overflow: requester 2 with operands 255,255 -> oRspData=510, oRspId=2.
REQ-030 Fairness: iReqValid=1111 held, iRspReady=1 -> grants in order 0,1,2,3,0 on consecutive cycles, one result per cycle. With ADDER_ARB_FIXED_PRIO_EN defined -> always 0.
REQ-031 Backpressure: result 30 held with iRspReady=0 for 3 cycles -> oRspData stays 30 and oReqReady=0000; raising iRspReady -> handshake, and a new grant in the same cycle.
REQ-032 Clear and enable: iClr=1 while FULL with iReqValid=0010 -> next cycle oRspValid=0 and no accept. With iEn=0 -> outputs and pointer frozen.
REQ-033 Async reset asserted mid-stream, then released -> all outputs 0 immediately, and the first grant goes to the lowest valid index.
